// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings, the JMP target
// field position and the fetch-stage IR occupancy states.
// Imported by instr_fetch and program_counter.
// Optional feature macro used by the fetch stage: JMP_FOLD_EN.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_INST_W = 16;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    // JMP target occupies inst[JMP_TGT_LSB +: ADDR_W]
    localparam int JMP_TGT_LSB = 8;

    typedef enum logic {
        IR_EMPTY = 1'b0,
        IR_FULL  = 1'b1
    } ir_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter: load / increment / hold with modulo 2^ADDR_W wrap.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pc <= RESET_PC)
//   load_en    load pc from load_addr (wins over inc_en)
//   load_addr  load value
//   inc_en     pc <= pc + 1, wrapping silently
//   pc         current program counter
module program_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load_en) begin
            pc <= load_addr;
        end else if (inc_en) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the program ROM address from the PC, registers the
// returned instruction into ir and offers it to decode over valid/ready.
// Handles execute-stage redirects and, with JMP_FOLD_EN defined, folds JMPs
// at fetch so they never reach decode.
//
// State table (ir_valid == state):
//   state    | meaning
//   IR_EMPTY | no instruction held; next ROM word is loaded unconditionally
//   IR_FULL  | ir holds an instruction offered to decode; holds until accepted
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rom_addr        ROM address (= pc, combinational)
//   rom_inst        ROM data for rom_addr, same cycle
//   ir_valid        ir holds an instruction for decode
//   ir_ready        decode accepts ir this cycle
//   ir, ir_pc       instruction register and the address it came from
//   redirect_valid  execute-stage taken branch/jump (flushes ir)
//   redirect_addr   redirect target
//   fetch_count     accepted handshakes, wraps at 16 bits
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int INST_W   = CPU_INST_W,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [15:0]       fetch_count
);

    ir_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              handshake;
    logic              fold;
    logic [ADDR_W-1:0] jmp_target;

    assign ir_valid  = (state == IR_FULL);
    assign load      = !ir_valid || ir_ready;
    assign handshake = ir_valid && ir_ready;
    assign rom_addr  = pc;

`ifdef JMP_FOLD_EN
    assign fold       = load && (rom_inst[INST_W-1 -: 4] == OP_JMP);
    assign jmp_target = rom_inst[JMP_TGT_LSB +: ADDR_W];
`else
    assign fold       = 1'b0;
    assign jmp_target = '0;
`endif

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_en   (redirect_valid || fold),
        .load_addr (redirect_valid ? redirect_addr : jmp_target),
        .inc_en    (load && !fold),
        .pc        (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IR_EMPTY;
            ir          <= '0;
            ir_pc       <= '0;
            fetch_count <= '0;
        end else begin
            // A handshake in a redirect cycle still counts; only ir is flushed.
            if (handshake) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect_valid) begin
                state <= IR_EMPTY;
            end else if (load) begin
                if (fold) begin
                    // Folded JMP: ir/ir_pc keep the already-consumed instruction.
                    state <= IR_EMPTY;
                end else begin
                    state <= IR_FULL;
                    ir    <= rom_inst;
                    ir_pc <= pc;
                end
            end
        end
    end

endmodule
